lc3_writeback_arbiter: RTL and testbench

//  Owns the LC3 8x16 general-purpose register file and sequences every write to it.

---
 rtl/lc3_writeback_arbiter.sv | 138 +++++++++++++
 tb/tb_lc3_writeback_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lc3_writeback_arbiter.sv
// LC3 writeback stage: owns the 8x16 register file, arbitrates ALU/load writebacks,
// drives VSR1/VSR2 reads and PSR condition codes. Define WB_BYPASS_EN for write-to-read bypass.
module lc3_writeback_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_wb_valid,
  output logic        alu_wb_ready,
  input  logic [2:0]  alu_wb_dr,
  input  logic [15:0] alu_wb_data,
  input  logic        alu_wb_set_cc,
  input  logic        mem_wb_valid,
  output logic        mem_wb_ready,
  input  logic [2:0]  mem_wb_dr,
  input  logic [15:0] mem_wb_data,
  input  logic [2:0]  sr1,
  input  logic [2:0]  sr2,
  output logic        enable_writeback,
  output logic [15:0] VSR1,
  output logic [15:0] VSR2,
  output logic [2:0]  psr
);

  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 3;
  localparam int unsigned NREG = 8;
  localparam int unsigned WCW  = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(STARVE_LIMIT);
  localparam logic [2:0] PSR_RESET = 3'b010;

  logic [DW-1:0]  rf_q [NREG];
  logic [WCW-1:0] wait_q, wait_d;
  logic [2:0]     psr_q, psr_d;
  logic [DW-1:0]  vsr1_q, vsr1_d;
  logic [DW-1:0]  vsr2_q, vsr2_d;
  logic           wb_en_q;

  logic           wr_en_c;
  logic [AW-1:0]  wr_dr_c;
  logic [DW-1:0]  wr_data_c;
  logic           wr_cc_c;

  // Grant: mem wins contention until the ALU has lost STARVE_LIMIT times in a row.
  always_comb begin
    alu_wb_ready = 1'b0;
    mem_wb_ready = 1'b0;
    if (!reset) begin
      if (alu_wb_valid && mem_wb_valid) begin
        if (wait_q == WAIT_MAX) begin
          alu_wb_ready = 1'b1;
        end else begin
          mem_wb_ready = 1'b1;
        end
      end else begin
        alu_wb_ready = alu_wb_valid;
        mem_wb_ready = mem_wb_valid;
      end
    end
  end

  // Select the winning write and whether it touches the condition codes.
  always_comb begin
    wr_en_c   = 1'b0;
    wr_dr_c   = '0;
    wr_data_c = '0;
    wr_cc_c   = 1'b0;
    if (alu_wb_valid && alu_wb_ready) begin
      wr_en_c   = 1'b1;
      wr_dr_c   = alu_wb_dr;
      wr_data_c = alu_wb_data;
      wr_cc_c   = alu_wb_set_cc;
    end else if (mem_wb_valid && mem_wb_ready) begin
      wr_en_c   = 1'b1;
      wr_dr_c   = mem_wb_dr;
      wr_data_c = mem_wb_data;
      wr_cc_c   = 1'b1;
    end
  end

  // Starvation counter: counts consecutive cycles the ALU waits.
  always_comb begin
    wait_d = wait_q;
    if (!alu_wb_valid || alu_wb_ready) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + WCW'(1);
    end
  end

  always_comb begin
    psr_d = psr_q;
    if (wr_en_c && wr_cc_c) begin
      psr_d = {wr_data_c[DW-1], wr_data_c == '0, !wr_data_c[DW-1] && (wr_data_c != '0)};
    end
  end

  always_comb begin
    vsr1_d = rf_q[sr1];
    vsr2_d = rf_q[sr2];
`ifdef WB_BYPASS_EN
    if (wr_en_c && (wr_dr_c == sr1)) begin
      vsr1_d = wr_data_c;
    end
    if (wr_en_c && (wr_dr_c == sr2)) begin
      vsr2_d = wr_data_c;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
      wait_q  <= '0;
      psr_q   <= PSR_RESET;
      vsr1_q  <= '0;
      vsr2_q  <= '0;
      wb_en_q <= 1'b0;
    end else begin
      if (wr_en_c) begin
        rf_q[wr_dr_c] <= wr_data_c;
      end
      wait_q  <= wait_d;
      psr_q   <= psr_d;
      vsr1_q  <= vsr1_d;
      vsr2_q  <= vsr2_d;
      wb_en_q <= wr_en_c;
    end
  end

  assign enable_writeback = wb_en_q;
  assign VSR1             = vsr1_q;
  assign VSR2             = vsr2_q;
  assign psr              = psr_q;

endmodule

// File: tb/tb_lc3_writeback_arbiter.sv
// Bench for lc3_writeback_arbiter: directed scenarios then random traffic against a reference model.
module tb_lc3_writeback_arbiter;

  localparam int LIMIT = 3;

  logic        clock;
  logic        rst;
  logic        av, acc, mv;
  logic [2:0]  adr, mdr, s1, s2;
  logic [15:0] ad, md;
  logic        alu_ready, mem_ready, ew;
  logic [15:0] vsr1, vsr2;
  logic [2:0]  psr;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] m_rf [8];
  logic [2:0]  m_psr;
  int          losses;
  logic        last_ga, last_gm;

  lc3_writeback_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(rst),
    .alu_wb_valid(av), .alu_wb_ready(alu_ready), .alu_wb_dr(adr),
    .alu_wb_data(ad), .alu_wb_set_cc(acc),
    .mem_wb_valid(mv), .mem_wb_ready(mem_ready), .mem_wb_dr(mdr), .mem_wb_data(md),
    .sr1(s1), .sr2(s2),
    .enable_writeback(ew), .VSR1(vsr1), .VSR2(vsr2), .psr(psr)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [2:0] cc_of(input logic [15:0] d);
    if (d == 16'h0000) return 3'b010;
    if (d[15]) return 3'b100;
    return 3'b001;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: check grants, advance the model, check registered outputs.
  task automatic tick();
    logic ga, gm, xfer, setcc;
    logic [2:0] dr;
    logic [15:0] d, e1, e2;
    logic e_ew;
    #1;
    ga = 1'b0;
    gm = 1'b0;
    if (!rst) begin
      if (av && mv) begin
        if (losses == LIMIT) ga = 1'b1; else gm = 1'b1;
      end else begin
        ga = av;
        gm = mv;
      end
    end
    chk("alu_ready", 16'(alu_ready), 16'(ga));
    chk("mem_ready", 16'(mem_ready), 16'(gm));
    last_ga = ga;
    last_gm = gm;
    xfer  = ga || gm;
    dr    = ga ? adr : mdr;
    d     = ga ? ad : md;
    setcc = gm || acc;
    e1 = m_rf[s1];
    e2 = m_rf[s2];
`ifdef WB_BYPASS_EN
    if (xfer && dr == s1) e1 = d;
    if (xfer && dr == s2) e2 = d;
`endif
    @(posedge clock);
    #1;
    if (rst) begin
      for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
      m_psr = 3'b010;
      e_ew = 1'b0;
      e1 = 16'h0000;
      e2 = 16'h0000;
      losses = 0;
    end else begin
      if (xfer) begin
        m_rf[dr] = d;
        if (setcc) m_psr = cc_of(d);
      end
      e_ew = xfer;
      if (av && !ga) losses = (losses < LIMIT) ? losses + 1 : LIMIT;
      else losses = 0;
    end
    chk("enable_writeback", 16'(ew), 16'(e_ew));
    chk("psr", 16'(psr), 16'(m_psr));
    chk("VSR1", vsr1, e1);
    chk("VSR2", vsr2, e2);
  endtask

  function automatic logic [15:0] rand_data();
    case ($urandom_range(0, 3))
      0: return 16'h0000;
      1: return 16'h8000 | 16'($urandom);
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [3:0] pat;
    logic [3:0] exp_pat;
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
    m_psr = 3'b010;
    losses = 0;
    rst = 1'b1; av = 1'b0; acc = 1'b0; mv = 1'b0;
    adr = 3'd0; mdr = 3'd0; ad = 16'h0; md = 16'h0; s1 = 3'd0; s2 = 3'd0;

    // T1: reset held two cycles
    tick();
    tick();
    chk("T1 VSR1", vsr1, 16'h0000);
    chk("T1 VSR2", vsr2, 16'h0000);
    chk("T1 psr", 16'(psr), 16'h0002);
    chk("T1 ew", 16'(ew), 16'h0000);

    // T2: single ALU write with condition codes
    rst = 1'b0;
    av = 1'b1; adr = 3'd3; ad = 16'h8001; acc = 1'b1;
    tick();
    chk("T2 grant", 16'(last_ga), 16'h0001);
    chk("T2 ew", 16'(ew), 16'h0001);
    chk("T2 psr", 16'(psr), 16'h0004);
    av = 1'b0; s1 = 3'd3;
    tick();
    chk("T2 VSR1", vsr1, 16'h8001);

    // T3: sustained contention, ALU wins on the fourth cycle
    av = 1'b1; adr = 3'd1; ad = 16'h0011; acc = 1'b1;
    mv = 1'b1; mdr = 3'd2; md = 16'h0022;
    pat = 4'b0000;
    exp_pat = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      tick();
      pat[i] = last_ga;
      chk("T3 mem grant", 16'(last_gm), 16'(!exp_pat[i]));
    end
    chk("T3 alu pattern", 16'(pat), 16'(exp_pat));
    tick();
    chk("T3 mem after alu", 16'(last_gm), 16'h0001);
    av = 1'b0; mv = 1'b0;
    tick();

    // T4: ALU write without cc leaves psr alone; load of zero sets Z
    mv = 1'b1; mdr = 3'd4; md = 16'h0005;
    tick();
    chk("T4 psr P", 16'(psr), 16'h0001);
    mv = 1'b0; av = 1'b1; adr = 3'd6; ad = 16'h0000; acc = 1'b0;
    tick();
    chk("T4 psr hold", 16'(psr), 16'h0001);
    av = 1'b0; mv = 1'b1; mdr = 3'd6; md = 16'h0000;
    tick();
    chk("T4 psr Z", 16'(psr), 16'h0002);
    mv = 1'b0;

    // T5: read/write collision on R5
    s1 = 3'd5; s2 = 3'd0;
    av = 1'b1; adr = 3'd5; ad = 16'h1234; acc = 1'b1;
    tick();
`ifdef WB_BYPASS_EN
    chk("T5 VSR1 same cycle", vsr1, 16'h1234);
`else
    chk("T5 VSR1 same cycle", vsr1, 16'h0000);
`endif
    av = 1'b0;
    tick();
    chk("T5 VSR1 next", vsr1, 16'h1234);

    // T6: reset in the grant cycle drops the write
    rst = 1'b1; av = 1'b1; adr = 3'd2; ad = 16'h00FF; acc = 1'b1;
    tick();
    chk("T6 ew", 16'(ew), 16'h0000);
    rst = 1'b0; av = 1'b0; s1 = 3'd2;
    tick();
    chk("T6 ew after", 16'(ew), 16'h0000);
    tick();
    chk("T6 R2", vsr1, 16'h0000);

    // Random traffic; requesters hold their payload until granted.
    for (int n = 0; n < 3000; n++) begin
      if (!(av && !last_ga)) begin
        av  = ($urandom_range(0, 2) != 0);
        adr = 3'($urandom);
        ad  = rand_data();
        acc = 1'($urandom);
      end
      if (!(mv && !last_gm)) begin
        mv  = ($urandom_range(0, 2) != 0);
        mdr = 3'($urandom);
        md  = rand_data();
      end
      s1  = 3'($urandom);
      s2  = ($urandom_range(0, 4) == 0) ? s1 : 3'($urandom);
      rst = ($urandom_range(0, 59) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
